// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_MADD  = 4'd2,
        OP_MADDU = 4'd3,
        OP_MSUB  = 4'd4,
        OP_MSUBU = 4'd5,
        OP_DIV   = 4'd6,
        OP_DIVU  = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } md_op_t;

    typedef logic [1:0] md_state_t;

    localparam md_state_t ST_IDLE = 2'd0;
    localparam md_state_t ST_MUL  = 2'd1;
    localparam md_state_t ST_DIV  = 2'd2;
    localparam md_state_t ST_FIX  = 2'd3;

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op <= OP_MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared engine: shift-add multiply (mode 0) or
// restoring divide (mode 1) on the {upper, lower} working pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_upper,
    output logic [WIDTH-1:0] next_lower
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply: add multiplicand on multiplier LSB, shift right with carry.
    // Divide: shift left, trial-subtract divisor, set quotient bit if it fits.
    always_comb begin
        sum     = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        shifted = {upper, lower[WIDTH-1]};
        ge      = (shifted >= {1'b0, operand});
        // Only used when ge, where the true difference is below the divisor.
        diff    = shifted[WIDTH-1:0] - operand;
        if (mode) begin
            next_upper = ge ? diff : shifted[WIDTH-1:0];
            next_lower = {lower[WIDTH-2:0], ge};
        end else begin
            next_upper = sum[WIDTH:1];
            next_lower = {sum[0], lower[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit owning the HI/LO accumulator pair.
//
// state | meaning
// IDLE  | waiting for a request; MTHI/MTLO and divide-by-zero handled here
// MUL   | one shift-add iteration per cycle, WIDTH cycles
// DIV   | one restoring-divide iteration per cycle, WIDTH cycles
// FIX   | apply signs, accumulate, write HI/LO
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mf_read,
    input  logic             mf_sel,
    input  logic             flush,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t        state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [3:0]       op_q;
    logic             sign_main, sign_rem;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s, acc_sum, acc_dif;
    logic [WIDTH-1:0] quo, rem;

    // Operand magnitudes and final sign correction.
    always_comb begin
        sa      = is_signed(op) & a[WIDTH-1];
        sb      = is_signed(op) & b[WIDTH-1];
        mag_a   = sa ? -a : a;
        mag_b   = sb ? -b : b;
        prod    = {acc_hi, acc_lo};
        prod_s  = sign_main ? -prod : prod;
        acc_sum = {hi, lo} + prod_s;
        acc_dif = {hi, lo} - prod_s;
        quo     = sign_main ? -acc_lo : acc_lo;
        rem     = sign_rem ? -acc_hi : acc_hi;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode       (state == ST_DIV),
        .upper      (acc_hi),
        .lower      (acc_lo),
        .operand    (opnd),
        .next_upper (step_hi),
        .next_lower (step_lo)
    );

    assign busy    = (state != ST_IDLE);
    assign stall   = busy & (start | mf_read);
    assign mf_data = mf_sel ? hi : lo;

    // Sequencer FSM, iteration counter and HI/LO update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            op_q      <= '0;
            sign_main <= 1'b0;
            sign_rem  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (op == OP_MTHI) begin
                                hi <= a;
                            end else if (op == OP_MTLO) begin
                                lo <= a;
                            end else if (is_mul(op)) begin
                                acc_hi    <= '0;
                                acc_lo    <= mag_b;
                                opnd      <= mag_a;
                                sign_main <= sa ^ sb;
                                op_q      <= op;
                                cnt       <= '0;
                                state     <= ST_MUL;
                            end else if (is_div(op)) begin
                                if (b == '0) begin
                                    div_zero <= 1'b1;
                                end else begin
                                    acc_hi    <= '0;
                                    acc_lo    <= mag_a;
                                    opnd      <= mag_b;
                                    sign_main <= sa ^ sb;
                                    sign_rem  <= sa;
                                    op_q      <= op;
                                    cnt       <= '0;
                                    state     <= ST_DIV;
                                end
                            end
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) state <= ST_FIX;
                    end
                    default: begin
                        if (is_div(op_q)) begin
                            lo <= quo;
                            hi <= rem;
                        end else if (op_q == OP_MULT || op_q == OP_MULTU) begin
                            {hi, lo} <= prod_s;
                        end else if (op_q == OP_MADD || op_q == OP_MADDU) begin
                            {hi, lo} <= acc_sum;
                        end else begin
                            {hi, lo} <= acc_dif;
                        end
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed timing scenarios plus
// randomized ops checked against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, mf_read, mf_sel, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [31:0] mf_data, hi, lo;
    logic        busy, stall, done, div_zero;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .mf_read(mf_read), .mf_sel(mf_sel), .flush(flush),
        .mf_data(mf_data), .hi(hi), .lo(lo), .busy(busy), .stall(stall),
        .done(done), .div_zero(div_zero)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference: HI/LO as a 64-bit value updated with ordinary arithmetic.
    task automatic model_apply(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xe, ye, p, acc, qv, rv;
        longint      sx, sy;
        exp_t        e;
        if (o <= 4'd5) begin
            if (o == 4'd0 || o == 4'd2 || o == 4'd4) begin
                xe = {{32{x[31]}}, x};
                ye = {{32{y[31]}}, y};
            end else begin
                xe = {32'b0, x};
                ye = {32'b0, y};
            end
            p   = xe * ye;
            acc = {m_hi, m_lo};
            if (o <= 4'd1)      acc = p;
            else if (o <= 4'd3) acc = acc + p;
            else                acc = acc - p;
            m_hi = acc[63:32];
            m_lo = acc[31:0];
            e = '{dz: 1'b0, hi: m_hi, lo: m_lo};
            sbq.push_back(e);
        end else if (o == 4'd6 || o == 4'd7) begin
            if (y == 32'd0) begin
                e = '{dz: 1'b1, hi: m_hi, lo: m_lo};
                sbq.push_back(e);
            end else begin
                if (o == 4'd6) begin
                    sx = longint'($signed(x));
                    sy = longint'($signed(y));
                end else begin
                    sx = longint'({32'b0, x});
                    sy = longint'({32'b0, y});
                end
                qv = sx / sy;
                rv = sx % sy;
                m_lo = qv[31:0];
                m_hi = rv[31:0];
                e = '{dz: 1'b0, hi: m_hi, lo: m_lo};
                sbq.push_back(e);
            end
        end else if (o == 4'd8) begin
            m_hi = x;
        end else if (o == 4'd9) begin
            m_lo = x;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        model_apply(o, x, y);
        tick();
        start = 1'b0; op = 4'd15;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({nm, "_timeout"}, 64'(busy), 64'd0);
        tick();
    endtask

    // Monitor: every Done or DivZero pulse retires one scoreboard entry.
    always begin
        @(negedge clk);
        if (!reset && (done || div_zero)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_result", {31'b0, done, 31'b0, div_zero}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_divzero", 64'(div_zero), 64'(mon_e.dz));
                chk("sb_hilo", {hi, lo}, {mon_e.hi, mon_e.lo});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        logic [31:0] sv_hi, sv_lo, x, y, lo1;
        logic [3:0]  o;

        reset = 1'b1; start = 1'b0; op = 4'd15; a = '0; b = '0;
        mf_read = 1'b0; mf_sel = 1'b0; flush = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_flags", {61'b0, busy, done, div_zero}, 64'd0);
        tick();
        reset = 1'b0;

        // 1: MULTU timing
        issue(4'd1, 32'hFFFF_FFFF, 32'd2);
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        chk("busy_window", 64'(bad), 64'd0);
        @(negedge clk);
        chk("done_cycle34", {62'b0, busy, done}, 64'd1);
        chk("multu_result", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        tick();

        // 2: signed multiply / accumulate
        issue(4'd0, -32'sd3, 32'd7);  wait_idle("mult");
        chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(4'd2, 32'd3, 32'd7);    wait_idle("madd");
        chk("madd_zero", {hi, lo}, 64'd0);
        issue(4'd4, 32'd1, 32'd1);    wait_idle("msub");
        chk("msub_wrap", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        // 3: division and its corner cases
        issue(4'd6, -32'sd7, 32'd2);  wait_idle("div");
        chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(4'd7, 32'd7, 32'd0);
        @(negedge clk);
        chk("divzero_pulse", {62'b0, busy, div_zero}, 64'd1);
        tick();
        chk("divzero_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        issue(4'd6, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle("div_ovf");
        chk("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

        // 4: stall on MF read, held request accepted in the done cycle
        op = 4'd1; a = 32'h1234_5678; b = 32'd9; start = 1'b1;
        mf_read = 1'b1; mf_sel = 1'b0;
        model_apply(4'd1, 32'h1234_5678, 32'd9);
        lo1 = m_lo;
        tick();
        op = 4'd3; a = 32'd3; b = 32'd5;
        bad = 0;
        for (int c = 1; c <= 33; c++) begin
            @(negedge clk);
            if (stall !== 1'b1) bad++;
            tick();
        end
        chk("stall_window", 64'(bad), 64'd0);
        @(negedge clk);
        chk("stall_release", 64'(stall), 64'd0);
        chk("mf_new_lo", 64'(mf_data), 64'(lo1));
        model_apply(4'd3, 32'd3, 32'd5);
        tick();
        start = 1'b0; mf_read = 1'b0; op = 4'd15;
        @(negedge clk);
        chk("held_accepted", 64'(busy), 64'd1);
        wait_idle("maddu");

        // 5: flush and reset aborts
        sv_hi = m_hi; sv_lo = m_lo;
        issue(4'd7, 32'd100, 32'd7);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        m_hi = sv_hi; m_lo = sv_lo;
        void'(sbq.pop_back());
        repeat (40) tick();
        chk("flush_hilo", {hi, lo}, {sv_hi, sv_lo});
        flush = 1'b1; start = 1'b1; op = 4'd8; a = 32'hDEAD;
        tick();
        flush = 1'b0; start = 1'b0; op = 4'd15;
        chk("flush_idle_override", 64'(hi), 64'(sv_hi));

        issue(4'd0, 32'd5, 32'd6);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_mid", {hi, lo}, 64'd0);
        chk("reset_mid_busy", 64'(busy), 64'd0);
        m_hi = '0; m_lo = '0;
        void'(sbq.pop_back());
        tick();

        // 6: MTHI then MFHI, NOP code
        issue(4'd8, 32'h1234, 32'd0);
        mf_read = 1'b1; mf_sel = 1'b1;
        @(negedge clk);
        chk("mfhi_data", 64'(mf_data), 64'h1234);
        chk("mfhi_nostall", 64'(stall), 64'd0);
        tick();
        mf_read = 1'b0;
        issue(4'd12, 32'h5555, 32'h6666);
        @(negedge clk);
        chk("nop_state", {hi, lo, 30'b0, busy, done}, {m_hi, m_lo, 32'd0});
        tick();

        // Random ops against the model
        for (int i = 0; i < 60; i++) begin
            o = 4'($urandom_range(0, 11));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) x = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) y = 32'hFFFF_FFFF;
            issue(o, x, y);
            wait_idle("rand");
            chk("rand_hilo", {hi, lo}, {m_hi, m_lo});
        end

        repeat (3) tick();
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit that owns the HI/LO accumulator pair.
- Accepts MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU/MTHI/MTLO requests issued by the decoder's ACCEn/MULOp path.
- Iterates one bit per cycle on a shared shift-add / restoring-divide engine.
- Stalls the pipeline when an MFHI/MFLO or a new request arrives while the engine is busy.
- Sits beside the ALU in the execute stage and replaces the single-cycle accumulator.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits, product is 2*WIDTH bits.

Ports:
Clock    in   1      rising-edge clock
Reset    in   1      synchronous, active-high reset
Start    in   1      request valid this cycle
Op       in   4      md_op_t: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO; 10-15 are NOP
A        in   WIDTH  rs operand (dividend/multiplicand; MTHI/MTLO data)
B        in   WIDTH  rt operand (divisor/multiplier)
MfRead   in   1      MFHI/MFLO in execute this cycle
MfSel    in   1      0 selects LO, 1 selects HI
Flush    in   1      pipeline flush; aborts an in-flight operation
MfData   out  WIDTH  combinational: MfSel ? HI : LO
HI       out  WIDTH  HI register
LO       out  WIDTH  LO register
Busy     out  1      engine in MUL, DIV or FIX state
Stall    out  1      combinational: Busy & (Start | MfRead)
Done     out  1      one-cycle pulse, first cycle new HI/LO are visible
DivZero  out  1      one-cycle pulse when DIV/DIVU has B == 0

Behaviour:
- Reset: state IDLE, HI = LO = 0, count = 0, Busy = Done = DivZero = 0. Reset has priority over everything else, including mid-operation.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE with Start and no Flush:
  - MTHI/MTLO: write A into HI/LO at this edge. Stay IDLE. No Done.
  - Any multiply op: latch |A| and |B| (signed ops) or raw values (unsigned ops), latch the result sign and the op. Clear the 2*WIDTH partial product, count = 0, go to MUL.
  - DIV/DIVU with B != 0: latch magnitudes, the quotient sign (sA ^ sB) and the remainder sign (sA). Clear the remainder, go to DIV.
  - DIV/DIVU with B == 0: DivZero pulses next cycle. HI/LO unchanged. Stay IDLE.
  - NOP codes: ignored.
- MUL: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of the product, then shift right one bit. count++. After WIDTH cycles go to FIX.
- DIV: restoring division. Shift {rem, quo} left one bit, trial-subtract the divisor, set the quotient bit if the result is non-negative. count++. After WIDTH cycles go to FIX.
- FIX (one cycle): apply signs and write HI/LO at the edge, then go to IDLE.
  - MULT*: {HI,LO} = P.
  - MADD*: {HI,LO} += P.
  - MSUB*: {HI,LO} -= P.
  - All 2*WIDTH arithmetic is modulo 2^(2*WIDTH).
  - DIV*: LO = quotient, HI = remainder.
  - Signed -2^(W-1) / -1 gives LO = 0x80000000, HI = 0 (natural wrap).
- Timing: Start sampled in cycle 0. Busy is high in cycles 1..WIDTH+1. HI/LO new values and Done are visible in cycle WIDTH+2 (34 for WIDTH = 32). Busy is low in that cycle.
- Start while Busy: ignored. Stall holds the pipeline, so the request is re-presented and accepted in the Done cycle.
- MfRead while Busy: Stall is high. In the Done cycle MfData already shows the new value and Stall is low.
- Flush:
  - In MUL/DIV/FIX: go to IDLE at the edge, HI/LO unchanged, no Done.
  - In IDLE: overrides Start.
- Decoder ACCEn without Start: no effect.

Decomposition:
- Package muldiv_pkg:
  - md_op_t enum with the encodings above.
  - md_state_t enum {IDLE, MUL, DIV, FIX}.
  - Helper functions is_signed(op), is_mul(op), is_div(op).
- One natural sub-module, muldiv_step: combinational single-iteration datapath (add-shift for multiply, trial-subtract-shift for divide), selected by a mode bit.
- The sequencer holds the FSM, counter, sign flags and HI/LO.

Test Plan:
1. Reset, then MULTU A=0xFFFFFFFF, B=2 -> Busy cycles 1-33; cycle 34: Done=1, HI=0x00000001, LO=0xFFFFFFFE.
2. MULT A=-3, B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MADD A=3, B=7 -> HI=0, LO=0; then MSUB A=1, B=1 -> HI=LO=0xFFFFFFFF.
3. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> DivZero pulse, Busy stays 0, HI/LO unchanged; DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
4. MULTU started, MfRead=1 MfSel=0 held -> Stall=1 cycles 1-33, Stall=0 in cycle 34 with MfData = new LO; a second Start held throughout is accepted in cycle 34.
5. DIVU started, Flush in cycle 10 -> Busy=0 in cycle 11, no Done, HI/LO keep prior values; Reset in cycle 5 of MULT -> next cycle HI=LO=0, IDLE.
6. MTHI A=0x1234 in cycle 0, MfRead MfSel=1 in cycle 1 -> MfData=0x1234, Stall=0; Op=12 with Start -> no state change.
